// File: rtl/vec_beat_packer_if.sv
// Handshake and beat bus between an element-pair source, the beat packer and the MAC.
// master = source/sink side, slave = packer side.
interface vec_beat_packer_if #(
    parameter int BUSW = 128
);
    logic            in_valid;
    logic            in_ready;
    logic [7:0]      in_a;
    logic [7:0]      in_b;
    logic            in_last;
    logic            vec_valid;
    logic [BUSW-1:0] vec_a;
    logic [BUSW-1:0] vec_b;
    logic            vec_done;
    logic            frame_err;

    modport master (
        output in_valid, in_a, in_b, in_last,
        input  in_ready, vec_valid, vec_a, vec_b, vec_done, frame_err
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last,
        output in_ready, vec_valid, vec_a, vec_b, vec_done, frame_err
    );
endinterface

// File: rtl/vec_beat_packer.sv
// Packs int8 (a, b) pairs into ACTIVE_LANES-wide beats for the vector MAC, framing
// each vector as ELEMS elements with a zero-padded tail beat and one idle cycle after it.
module vec_beat_packer #(
    parameter int ELEMS        = 1000,
    parameter int ACTIVE_LANES = 1,
    parameter int BUSW         = 128
) (
    input  logic              clk,
    input  logic              rst,
    vec_beat_packer_if.slave  bus
);
    localparam int CNT_W  = $clog2(ELEMS) + 1;
    localparam int LIDX_W = (ACTIVE_LANES > 1) ? $clog2(ACTIVE_LANES) : 1;
    localparam int STG_W  = ACTIVE_LANES * 8;

    localparam logic [CNT_W-1:0]  LAST_ELEM = CNT_W'(ELEMS - 1);
    localparam logic [LIDX_W-1:0] LAST_LANE = LIDX_W'(ACTIVE_LANES - 1);

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_GAP  = 1'b1;

    logic [0:0]        state_q,     state_d;
    logic [CNT_W-1:0]  elem_cnt_q,  elem_cnt_d;
    logic [LIDX_W-1:0] lane_idx_q,  lane_idx_d;
    logic [STG_W-1:0]  stage_a_q,   stage_a_d;
    logic [STG_W-1:0]  stage_b_q,   stage_b_d;
    logic              vec_valid_q, vec_valid_d;
    logic              vec_done_q,  vec_done_d;
    logic              frame_err_q, frame_err_d;
    logic [BUSW-1:0]   vec_a_q,     vec_a_d;
    logic [BUSW-1:0]   vec_b_q,     vec_b_d;

    logic [STG_W-1:0]  merged_a_s;
    logic [STG_W-1:0]  merged_b_s;
    logic              ready_s;
    logic              accept_s;
    logic              last_elem_s;
    logic              beat_end_s;

    assign ready_s     = (state_q == ST_FILL) && !rst;
    assign accept_s    = bus.in_valid && ready_s;
    assign last_elem_s = (elem_cnt_q == LAST_ELEM);
    assign beat_end_s  = accept_s && ((lane_idx_q == LAST_LANE) || last_elem_s);

    // Staging contents with the incoming pair dropped into the current lane.
    always_comb begin
        merged_a_s = stage_a_q;
        merged_b_s = stage_b_q;
        for (int l = 0; l < ACTIVE_LANES; l++) begin
            if (lane_idx_q == LIDX_W'(l)) begin
                merged_a_s[l*8 +: 8] = bus.in_a;
                merged_b_s[l*8 +: 8] = bus.in_b;
            end else begin
                merged_a_s[l*8 +: 8] = stage_a_q[l*8 +: 8];
                merged_b_s[l*8 +: 8] = stage_b_q[l*8 +: 8];
            end
        end
    end

    // Next-state: counters, staging, beat launch and framing check.
    always_comb begin
        state_d     = state_q;
        elem_cnt_d  = elem_cnt_q;
        lane_idx_d  = lane_idx_q;
        stage_a_d   = stage_a_q;
        stage_b_d   = stage_b_q;
        vec_valid_d = 1'b0;
        vec_done_d  = 1'b0;
        vec_a_d     = vec_a_q;
        vec_b_d     = vec_b_q;
        frame_err_d = frame_err_q;
        case (state_q)
            ST_FILL: begin
                if (accept_s) begin
                    if (last_elem_s) begin
                        elem_cnt_d = {CNT_W{1'b0}};
                        lane_idx_d = {LIDX_W{1'b0}};
                        state_d    = ST_GAP;
                    end else begin
                        elem_cnt_d = elem_cnt_q + CNT_W'(1);
                        lane_idx_d = (lane_idx_q == LAST_LANE) ? {LIDX_W{1'b0}}
                                                               : lane_idx_q + LIDX_W'(1);
                        state_d    = ST_FILL;
                    end
                    // The MAC cannot stall, so a finished beat leaves the staging area at once.
                    if (beat_end_s) begin
                        stage_a_d               = {STG_W{1'b0}};
                        stage_b_d               = {STG_W{1'b0}};
                        vec_valid_d             = 1'b1;
                        vec_done_d              = last_elem_s;
                        vec_a_d                 = {BUSW{1'b0}};
                        vec_b_d                 = {BUSW{1'b0}};
                        vec_a_d[STG_W-1:0]      = merged_a_s;
                        vec_b_d[STG_W-1:0]      = merged_b_s;
                    end else begin
                        stage_a_d = merged_a_s;
                        stage_b_d = merged_b_s;
                    end
                    if (bus.in_last != last_elem_s) begin
                        frame_err_d = 1'b1;
                    end else begin
                        frame_err_d = frame_err_q;
                    end
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_GAP: begin
                state_d = ST_FILL;
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FILL;
            elem_cnt_q  <= {CNT_W{1'b0}};
            lane_idx_q  <= {LIDX_W{1'b0}};
            stage_a_q   <= {STG_W{1'b0}};
            stage_b_q   <= {STG_W{1'b0}};
            vec_valid_q <= 1'b0;
            vec_done_q  <= 1'b0;
            frame_err_q <= 1'b0;
            vec_a_q     <= {BUSW{1'b0}};
            vec_b_q     <= {BUSW{1'b0}};
        end else begin
            state_q     <= state_d;
            elem_cnt_q  <= elem_cnt_d;
            lane_idx_q  <= lane_idx_d;
            stage_a_q   <= stage_a_d;
            stage_b_q   <= stage_b_d;
            vec_valid_q <= vec_valid_d;
            vec_done_q  <= vec_done_d;
            frame_err_q <= frame_err_d;
            vec_a_q     <= vec_a_d;
            vec_b_q     <= vec_b_d;
        end
    end

    assign bus.in_ready  = ready_s;
    assign bus.vec_valid = vec_valid_q;
    assign bus.vec_done  = vec_done_q;
    assign bus.frame_err = frame_err_q;
    assign bus.vec_a     = vec_a_q;
    assign bus.vec_b     = vec_b_q;

endmodule
